// File: rtl/swb_pkg.sv
// Shared types, sizing constants and the word-address compare for the store write buffer.
package swb_pkg;

    localparam int unsigned SWB_DEPTH  = 4;
    localparam int unsigned SWB_ADDR_W = 32;
    localparam int unsigned SWB_DATA_W = 32;
    localparam int unsigned PTR_W      = $clog2(SWB_DEPTH);

    typedef struct packed {
        logic                  valid;
        logic [SWB_ADDR_W-1:0] addr;
        logic [SWB_DATA_W-1:0] data;
    } swb_entry_t;

    // Stores are whole words, so only the word address takes part in a match.
    function automatic logic word_match(input logic [SWB_ADDR_W-1:0] a,
                                        input logic [SWB_ADDR_W-1:0] b);
        return (a >> 2) == (b >> 2);
    endfunction

endpackage

// File: rtl/swb_fwd_cam.sv
// Combinational forwarding search: finds the youngest valid buffered store whose word
// address matches the load address.
module swb_fwd_cam
    import swb_pkg::*;
(
    input  swb_entry_t            entries [SWB_DEPTH],
    input  logic [PTR_W-1:0]      rdPtr,
    input  logic [SWB_ADDR_W-1:0] loadAddress,
    output logic                  hit,
    output logic [SWB_DATA_W-1:0] data
);

    always_comb begin
        hit  = 1'b0;
        data = '0;
        // Walk from the head (oldest) forwards so the last match seen is the youngest.
        for (int unsigned i = 0; i < SWB_DEPTH; i++) begin
            if (entries[rdPtr + PTR_W'(i)].valid &&
                word_match(entries[rdPtr + PTR_W'(i)].addr, loadAddress)) begin
                hit  = 1'b1;
                data = entries[rdPtr + PTR_W'(i)].data;
            end
        end
    end

endmodule

// File: rtl/store_write_buffer.sv
// Posted-store FIFO between the core data port and a slower memory bus, with
// youngest-match load forwarding and a registered full stall.
module store_write_buffer
    import swb_pkg::*;
#(
    parameter int unsigned DEPTH  = SWB_DEPTH,
    parameter int unsigned ADDR_W = SWB_ADDR_W,
    parameter int unsigned DATA_W = SWB_DATA_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   MemWrite,
    input  logic [ADDR_W-1:0]      DataAddress,
    input  logic [DATA_W-1:0]      WriteData,
    output logic                   StoreStall,
    input  logic [ADDR_W-1:0]      LoadAddress,
    output logic                   LoadHit,
    output logic [DATA_W-1:0]      LoadData,
    output logic                   BusValid,
    output logic [ADDR_W-1:0]      BusAddr,
    output logic [DATA_W-1:0]      BusData,
    input  logic                   BusReady,
    output logic                   Empty,
    output logic [$clog2(DEPTH):0] Count
);

    localparam int unsigned CntW = PTR_W + 1;
    localparam logic [PTR_W-1:0] PtrOne  = 1;
    localparam logic [CntW-1:0]  CntOne  = 1;
    localparam logic [CntW-1:0]  CntFull = CntW'(DEPTH);

    // The entry type is sized by the package, so the instance must agree with it.
    if (DEPTH != SWB_DEPTH || ADDR_W != SWB_ADDR_W || DATA_W != SWB_DATA_W) begin : gParamCheck
        $error("store_write_buffer: DEPTH/ADDR_W/DATA_W must match swb_pkg");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : gDepthCheck
        $error("store_write_buffer: DEPTH must be a power of two >= 2");
    end

    swb_entry_t       entries [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [CntW-1:0]  count;
    logic             push;
    logic             pop;

    assign Empty      = (count == '0);
    assign StoreStall = (count == CntFull);
    assign BusValid   = !Empty;
    assign BusAddr    = BusValid ? entries[rdPtr].addr : '0;
    assign BusData    = BusValid ? entries[rdPtr].data : '0;
    assign Count      = count;

    // Stall is decoded from registered state only, so a store arriving while full is
    // dropped even if the bus drains an entry in the same cycle.
    assign push = MemWrite && !StoreStall;
    assign pop  = BusValid && BusReady;

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries[i].valid <= 1'b0;
            end
        end else begin
            if (push) begin
                entries[wrPtr] <= '{valid: 1'b1, addr: DataAddress, data: WriteData};
                wrPtr          <= wrPtr + PtrOne;
            end
            if (pop) begin
                entries[rdPtr].valid <= 1'b0;
                rdPtr                <= rdPtr + PtrOne;
            end
            case ({push, pop})
                2'b10:   count <= count + CntOne;
                2'b01:   count <= count - CntOne;
                default: count <= count;
            endcase
        end
    end

    swb_fwd_cam u_fwd_cam (
        .entries     (entries),
        .rdPtr       (rdPtr),
        .loadAddress (LoadAddress),
        .hit         (LoadHit),
        .data        (LoadData)
    );

endmodule

// File: tb/tb_store_write_buffer.sv
// Bench for store_write_buffer: directed vector table, corner-case sequences, and a
// queue-based reference model driven by random traffic.
module tb_store_write_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite;
    logic [31:0] DataAddress;
    logic [31:0] WriteData;
    logic        StoreStall;
    logic [31:0] LoadAddress;
    logic        LoadHit;
    logic [31:0] LoadData;
    logic        BusValid;
    logic [31:0] BusAddr;
    logic [31:0] BusData;
    logic        BusReady;
    logic        Empty;
    logic [2:0]  Count;

    always #5 clk = ~clk;

    store_write_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .MemWrite    (MemWrite),
        .DataAddress (DataAddress),
        .WriteData   (WriteData),
        .StoreStall  (StoreStall),
        .LoadAddress (LoadAddress),
        .LoadHit     (LoadHit),
        .LoadData    (LoadData),
        .BusValid    (BusValid),
        .BusAddr     (BusAddr),
        .BusData     (BusData),
        .BusReady    (BusReady),
        .Empty       (Empty),
        .Count       (Count)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [31:0] rst, mw, addr, data, rdy, la;
        logic [31:0] bv, ba, bd, cnt, st, em, hit, ld;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [31:0] rst, mw, addr, data, rdy, la,
                                input logic [31:0] bv, ba, bd, cnt, st, em, hit, ld);
        vec_t v;
        v.rst = rst; v.mw = mw; v.addr = addr; v.data = data; v.rdy = rdy; v.la = la;
        v.bv = bv; v.ba = ba; v.bd = bd; v.cnt = cnt; v.st = st; v.em = em;
        v.hit = hit; v.ld = ld;
        return v;
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } store_t;

    store_t      model[$];
    logic [63:0] drained[$];

    // Youngest store to the same word wins; search from the tail backwards.
    function automatic void fwd(input logic [31:0] la, output logic h, output logic [31:0] d);
        h = 1'b0;
        d = '0;
        for (int i = model.size() - 1; i >= 0; i--) begin
            if (model[i].addr[31:2] == la[31:2]) begin
                h = 1'b1;
                d = model[i].data;
                break;
            end
        end
    endfunction

    // Drive one cycle, compare pre-edge outputs against the model, then advance both.
    task automatic cycle(input logic rst, input logic mw, input logic [31:0] a,
                         input logic [31:0] d, input logic rdy, input logic [31:0] la,
                         input string tag);
        logic        h;
        logic [31:0] ld;
        bit          doPush;
        reset = rst; MemWrite = mw; DataAddress = a; WriteData = d;
        BusReady = rdy; LoadAddress = la;
        #1;
        fwd(la, h, ld);
        check({tag, "/count"}, 32'(Count), 32'(model.size()));
        check({tag, "/stall"}, 32'(StoreStall), 32'(model.size() == DEPTH));
        check({tag, "/empty"}, 32'(Empty), 32'(model.size() == 0));
        check({tag, "/busValid"}, 32'(BusValid), 32'(model.size() != 0));
        check({tag, "/busAddr"}, BusAddr, (model.size() != 0) ? model[0].addr : 32'h0);
        check({tag, "/busData"}, BusData, (model.size() != 0) ? model[0].data : 32'h0);
        check({tag, "/loadHit"}, 32'(LoadHit), 32'(h));
        check({tag, "/loadData"}, LoadData, ld);
        if (BusValid && rdy) drained.push_back({BusAddr, BusData});
        if (rst) begin
            model.delete();
        end else begin
            doPush = mw && (model.size() < DEPTH);
            if (model.size() != 0 && rdy) void'(model.pop_front());
            if (doPush) model.push_back('{addr: a, data: d});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulseReset();
        reset = 1'b1; MemWrite = 1'b0; BusReady = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; MemWrite = 1'b0; DataAddress = '0; WriteData = '0;
        BusReady = 1'b0; LoadAddress = '0;

        //           rst mw addr   data rdy la       bv ba     bd   cnt st em hit ld
        vecs.push_back(mk(1, 0, 'h00, 'h00, 0, 'h00,  0, 'h00, 'h00, 0, 0, 1, 0, 'h00));
        vecs.push_back(mk(0, 1, 'h64, 'h07, 1, 'h64,  1, 'h64, 'h07, 1, 0, 0, 1, 'h07));
        vecs.push_back(mk(0, 0, 'h00, 'h00, 1, 'h64,  0, 'h00, 'h00, 0, 0, 1, 0, 'h00));
        vecs.push_back(mk(0, 1, 'h00, 'hA0, 0, 'h08,  1, 'h00, 'hA0, 1, 0, 0, 0, 'h00));
        vecs.push_back(mk(0, 1, 'h04, 'hA1, 0, 'h04,  1, 'h00, 'hA0, 2, 0, 0, 1, 'hA1));
        vecs.push_back(mk(0, 1, 'h08, 'hA2, 0, 'h08,  1, 'h00, 'hA0, 3, 0, 0, 1, 'hA2));
        vecs.push_back(mk(0, 1, 'h0C, 'hA3, 0, 'h0C,  1, 'h00, 'hA0, 4, 1, 0, 1, 'hA3));
        vecs.push_back(mk(0, 1, 'h10, 'hA4, 0, 'h10,  1, 'h00, 'hA0, 4, 1, 0, 0, 'h00));
        vecs.push_back(mk(0, 0, 'h00, 'h00, 1, 'h00,  1, 'h04, 'hA1, 3, 0, 0, 0, 'h00));
        vecs.push_back(mk(0, 0, 'h00, 'h00, 1, 'h00,  1, 'h08, 'hA2, 2, 0, 0, 0, 'h00));
        vecs.push_back(mk(0, 0, 'h00, 'h00, 1, 'h00,  1, 'h0C, 'hA3, 1, 0, 0, 0, 'h00));
        vecs.push_back(mk(0, 0, 'h00, 'h00, 1, 'h00,  0, 'h00, 'h00, 0, 0, 1, 0, 'h00));
        vecs.push_back(mk(0, 1, 'h30, 'hB0, 0, 'h00,  1, 'h30, 'hB0, 1, 0, 0, 0, 'h00));
        vecs.push_back(mk(0, 1, 'h34, 'hB1, 0, 'h00,  1, 'h30, 'hB0, 2, 0, 0, 0, 'h00));
        vecs.push_back(mk(0, 1, 'h38, 'hB2, 1, 'h38,  1, 'h34, 'hB1, 2, 0, 0, 1, 'hB2));
        vecs.push_back(mk(0, 0, 'h00, 'h00, 1, 'h38,  1, 'h38, 'hB2, 1, 0, 0, 1, 'hB2));
        vecs.push_back(mk(0, 0, 'h00, 'h00, 1, 'h38,  0, 'h00, 'h00, 0, 0, 1, 0, 'h00));
        vecs.push_back(mk(0, 1, 'h20, 'h01, 0, 'h20,  1, 'h20, 'h01, 1, 0, 0, 1, 'h01));
        vecs.push_back(mk(0, 1, 'h20, 'h09, 0, 'h20,  1, 'h20, 'h01, 2, 0, 0, 1, 'h09));
        vecs.push_back(mk(0, 1, 'h22, 'h05, 0, 'h20,  1, 'h20, 'h01, 3, 0, 0, 1, 'h05));
        vecs.push_back(mk(0, 0, 'h00, 'h00, 0, 'h24,  1, 'h20, 'h01, 3, 0, 0, 0, 'h00));
        vecs.push_back(mk(0, 0, 'h00, 'h00, 0, 'h21,  1, 'h20, 'h01, 3, 0, 0, 1, 'h05));
        vecs.push_back(mk(1, 0, 'h00, 'h00, 0, 'h20,  0, 'h00, 'h00, 0, 0, 1, 0, 'h00));

        foreach (vecs[i]) begin
            reset = vecs[i].rst[0]; MemWrite = vecs[i].mw[0];
            DataAddress = vecs[i].addr; WriteData = vecs[i].data;
            BusReady = vecs[i].rdy[0]; LoadAddress = vecs[i].la;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d.busValid", i), 32'(BusValid), vecs[i].bv);
            check($sformatf("vec%0d.busAddr", i), BusAddr, vecs[i].ba);
            check($sformatf("vec%0d.busData", i), BusData, vecs[i].bd);
            check($sformatf("vec%0d.count", i), 32'(Count), vecs[i].cnt);
            check($sformatf("vec%0d.stall", i), 32'(StoreStall), vecs[i].st);
            check($sformatf("vec%0d.empty", i), 32'(Empty), vecs[i].em);
            check($sformatf("vec%0d.loadHit", i), 32'(LoadHit), vecs[i].hit);
            check($sformatf("vec%0d.loadData", i), LoadData, vecs[i].ld);
        end

        // A store is not forwardable in its push cycle, but is in its pop cycle.
        pulseReset();
        MemWrite = 1'b1; DataAddress = 32'h40; WriteData = 32'h11; LoadAddress = 32'h40;
        #1;
        check("fwdPushSame.hit", 32'(LoadHit), 32'h0);
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
        #1;
        check("fwdAfterPush.hit", 32'(LoadHit), 32'h1);
        check("fwdAfterPush.data", LoadData, 32'h11);
        BusReady = 1'b1;
        #1;
        check("fwdPopSame.hit", 32'(LoadHit), 32'h1);
        check("fwdPopSame.data", LoadData, 32'h11);
        @(posedge clk);
        #1;
        BusReady = 1'b0;
        #1;
        check("fwdAfterPop.hit", 32'(LoadHit), 32'h0);
        check("fwdAfterPop.empty", 32'(Empty), 32'h1);

        // Full with a pop in the same cycle: the store is still rejected.
        pulseReset();
        for (int i = 0; i < 4; i++) begin
            MemWrite = 1'b1; DataAddress = 32'h60 + 32'(4 * i); WriteData = 32'hD0 + 32'(i);
            @(posedge clk);
            #1;
        end
        DataAddress = 32'h70; WriteData = 32'hEE; BusReady = 1'b1;
        #1;
        check("fullPop.stallBefore", 32'(StoreStall), 32'h1);
        check("fullPop.countBefore", 32'(Count), 32'h4);
        @(posedge clk);
        #1;
        MemWrite = 1'b0; BusReady = 1'b0; LoadAddress = 32'h70;
        #1;
        check("fullPop.count", 32'(Count), 32'h3);
        check("fullPop.busAddr", BusAddr, 32'h64);
        check("fullPop.busData", BusData, 32'hD1);
        check("fullPop.rejectedHit", 32'(LoadHit), 32'h0);
        check("fullPop.stallAfter", 32'(StoreStall), 32'h0);

        // Ten held-while-stalled stores with BusReady toggling each cycle.
        pulseReset();
        drained.delete();
        begin
            int   k   = 0;
            int   cyc = 0;
            logic rdyT = 1'b0;
            bit   accept;
            while ((k < 10 || model.size() != 0) && cyc < 80) begin
                accept = (k < 10) && (model.size() < DEPTH);
                cycle(1'b0, k < 10, 32'h200 + 32'(4 * k), 32'hC0DE0000 + 32'(k), rdyT,
                      32'h200 + 32'(4 * (k % 4)), "wrap");
                check("wrap.countBound", 32'(Count > 3'd4), 32'h0);
                if (accept) k++;
                rdyT = ~rdyT;
                cyc++;
            end
            check("wrap.drainedCount", 32'(drained.size()), 32'd10);
            for (int i = 0; i < drained.size() && i < 10; i++) begin
                check($sformatf("wrap.drainAddr%0d", i), drained[i][63:32],
                      32'h200 + 32'(4 * i));
                check($sformatf("wrap.drainData%0d", i), drained[i][31:0],
                      32'hC0DE0000 + 32'(i));
            end
        end

        // Random traffic against the queue model, including occasional resets.
        pulseReset();
        for (int n = 0; n < 400; n++) begin
            cycle($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
                  32'h100 + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3), $urandom,
                  $urandom_range(0, 2) != 0,
                  32'h100 + ($urandom_range(0, 9) << 2) + $urandom_range(0, 3), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
